// File: rtl/jtframe_pll_phstep.sv
// Run-time phase-shift controller for the SDRAM clock output of the PLL.
// Walks the PLL phase one VCO step at a time towards a requested signed
// offset, following the phasestep / phasedone handshake. Each wait for a
// phasedone edge is bounded by a timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no stepping; accepts req while the PLL is locked
// STEP      | phasestep held high for two cycles
// WAIT_LOW  | waiting for phasedone to fall (step in progress)
// WAIT_HIGH | waiting for phasedone to rise (step finished)
// CHECK     | apply +/-1 to cur, then finish or start the next step
module jtframe_pll_phstep #(
  parameter int              STEPW  = 6,
  parameter int              CNTW   = 4,
  parameter logic [CNTW-1:0] CNTSEL = 4'd1,
  parameter int              TO     = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    locked,
  input  logic                    req,
  input  logic signed [STEPW-1:0] target,
  output logic                    busy,
  output logic                    ack,
  output logic signed [STEPW-1:0] cur,
  output logic                    err,
  output logic [CNTW-1:0]         phasecounterselect,
  output logic                    phasestep,
  output logic                    phaseupdown,
  input  logic                    phasedone
);

  // The wait counter is loaded with TO-1 and runs down to zero, so a wait
  // state gives up in its TO-th cycle.
  localparam int            TW        = (TO > 1) ? $clog2(TO) : 1;
  localparam logic [TW-1:0] WAIT_LOAD = TW'(TO - 1);

  typedef enum logic [2:0] {
    IDLE,
    STEP,
    WAIT_LOW,
    WAIT_HIGH,
    CHECK
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic                      step_cnt;
  logic [TW-1:0]             wait_cnt;
  logic signed [STEPW-1:0]   tgt;
  logic signed [STEPW-1:0]   cur_step;

  logic accept;
  logic same;
  logic load_step;
  logic load_wait;
  logic timeout;
  logic advance;
  logic hit;

  assign cur_step = phaseupdown ? cur + STEPW'(1) : cur - STEPW'(1);

  assign busy               = (state_q != IDLE);
  assign phasestep          = (state_q == STEP);
  assign phasecounterselect = CNTSEL;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic and single-cycle control strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    same      = 1'b0;
    load_step = 1'b0;
    load_wait = 1'b0;
    timeout   = 1'b0;
    advance   = 1'b0;
    hit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && locked) begin
          accept = 1'b1;
          if (target == cur) begin
            same = 1'b1;
          end else begin
            state_d   = STEP;
            load_step = 1'b1;
          end
        end
      end
      STEP: begin
        if (step_cnt == 1'b0) begin
          state_d   = WAIT_LOW;
          load_wait = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!phasedone) begin
          state_d   = WAIT_HIGH;
          load_wait = 1'b1;
        end else if (wait_cnt == '0) begin
          state_d = IDLE;
          timeout = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (phasedone) begin
          state_d = CHECK;
        end else if (wait_cnt == '0) begin
          state_d = IDLE;
          timeout = 1'b1;
        end
      end
      CHECK: begin
        advance = 1'b1;
        if (cur_step == tgt) begin
          state_d = IDLE;
          hit     = 1'b1;
        end else begin
          state_d   = STEP;
          load_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Losing lock mid-operation abandons the sequence without side effects
    if (!locked && state_q != IDLE) begin
      state_d   = IDLE;
      load_step = 1'b0;
      load_wait = 1'b0;
      timeout   = 1'b0;
      advance   = 1'b0;
      hit       = 1'b0;
    end
  end

  // step-length and handshake-timeout down-counters
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (load_step)               step_cnt <= 1'b1;
      else if (state_q == STEP)    step_cnt <= 1'b0;
      if (load_wait)               wait_cnt <= WAIT_LOAD;
      else if (wait_cnt != '0)     wait_cnt <= wait_cnt - TW'(1);
    end
  end

  // request latch, direction, applied offset and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= '0;
      tgt         <= '0;
      err         <= 1'b0;
      ack         <= 1'b0;
      phaseupdown <= 1'b0;
    end else begin
      ack <= same | hit;
      if (accept) begin
        tgt <= target;
        err <= 1'b0;
        if (!same) phaseupdown <= (target > cur);
      end
      if (timeout) err <= 1'b1;
      // A relocking PLL comes back at its compile-time phase
      if (!locked)      cur <= '0;
      else if (advance) cur <= cur_step;
    end
  end

endmodule

// File: tb/tb_jtframe_pll_phstep.sv
// Bench for jtframe_pll_phstep: table of requests, hand-written corner
// sequences (timing, timeout, lock loss) and random requests checked
// against an arithmetic model of the applied phase offset.
module tb_jtframe_pll_phstep;

  logic              clk = 1'b0;
  logic              rst;
  logic              locked;
  logic              req;
  logic signed [5:0] target;
  logic              busy;
  logic              ack;
  logic signed [5:0] cur;
  logic              err;
  logic [3:0]        pcs;
  logic              phasestep;
  logic              phaseupdown;
  logic              phasedone;

  int n_checks = 0;
  int n_pass   = 0;

  jtframe_pll_phstep #(
    .STEPW (6),
    .CNTW  (4),
    .CNTSEL(4'd1),
    .TO    (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .locked            (locked),
    .req               (req),
    .target            (target),
    .busy              (busy),
    .ack               (ack),
    .cur               (cur),
    .err               (err),
    .phasecounterselect(pcs),
    .phasestep         (phasestep),
    .phaseupdown       (phaseupdown),
    .phasedone         (phasedone)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // PLL model: phasedone goes low pll_dly cycles after a phasestep rise
  // and stays low for pll_len cycles; stuck keeps it high forever.
  int   since   = 0;
  int   pll_dly = 3;
  int   pll_len = 4;
  bit   stuck   = 1'b0;
  logic ps_prev_pll = 1'b0;

  initial begin
    phasedone = 1'b1;
    forever begin
      @(negedge clk);
      if (phasestep && !ps_prev_pll) since = 1;
      else if (since > 0)            since++;
      if (since > pll_dly + pll_len) since = 0;
      ps_prev_pll = phasestep;
      phasedone = stuck || !(since >= pll_dly + 1 && since <= pll_dly + pll_len);
    end
  end

  // Monitor: counts phasestep pulses and ack pulses, checks pulse width
  // and that the direction stays constant over each busy period.
  int   ps_rises = 0;
  int   ack_cnt  = 0;
  int   ps_width = 0;
  logic ps_prev_m = 1'b0;
  logic busy_prev = 1'b0;
  logic upd_ref   = 1'b0;
  logic upd_bad   = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (phasestep) begin
        if (!ps_prev_m) begin
          ps_rises++;
          ps_width = 0;
        end
        ps_width++;
      end else if (ps_prev_m) begin
        check("phasestep_width", ps_width, 2);
      end
      if (ack) ack_cnt++;
      if (busy && !busy_prev) begin
        upd_ref = phaseupdown;
        upd_bad = 1'b0;
      end else if (busy && phaseupdown !== upd_ref) begin
        upd_bad = 1'b1;
      end
      if (!busy && busy_prev) check("updown_held", upd_bad, 0);
      ps_prev_m = phasestep;
      busy_prev = busy;
    end
  end

  task automatic do_req(input int t);
    req    = 1'b1;
    target = 6'(t);
    @(negedge clk);
    req    = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
    check("idle_reached", busy, 0);
  endtask

  task automatic run_req(input string name, input int t, input bit inj,
                         input int exp_pulses, input bit exp_upd, input int exp_cur);
    int b_ps;
    int b_ack;
    b_ps  = ps_rises;
    b_ack = ack_cnt;
    do_req(t);
    if (inj) begin
      repeat (4) @(negedge clk);
      if (busy) begin
        req    = 1'b1;
        target = ~6'(t);
        @(negedge clk);
        req    = 1'b0;
      end
    end
    wait_idle();
    @(negedge clk);
    check({name, "_cur"},    cur, exp_cur);
    check({name, "_pulses"}, ps_rises - b_ps, exp_pulses);
    check({name, "_acks"},   ack_cnt - b_ack, 1);
    check({name, "_err"},    err, 0);
    if (exp_pulses > 0) check({name, "_updown"}, phaseupdown, exp_upd);
  endtask

  typedef struct {
    int tgt;
    bit inj;
    int pulses;
    bit upd;
    int cur_e;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int b_ack;
    int rises;
    logic pprev;
    int model_cur;
    int t;
    int pulses;

    vecs[0] = '{3,   1'b0, 3,  1'b1, 3};
    vecs[1] = '{-2,  1'b1, 5,  1'b0, -2};
    vecs[2] = '{-2,  1'b0, 0,  1'b0, -2};
    vecs[3] = '{31,  1'b0, 33, 1'b1, 31};
    vecs[4] = '{-32, 1'b1, 63, 1'b0, -32};
    vecs[5] = '{0,   1'b1, 32, 1'b1, 0};

    rst = 1'b1; locked = 1'b1; req = 1'b0; target = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_cur", cur, 0);
    check("rst_err", err, 0);
    check("rst_phasestep", phasestep, 0);
    check("rst_phaseupdown", phaseupdown, 0);
    check("rst_cntsel", pcs, 1);

    foreach (vecs[i])
      run_req($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].inj,
              vecs[i].pulses, vecs[i].upd, vecs[i].cur_e);

    // equal target: ack right away, no stepping
    do_req(0);
    check("eq_ack_n1", ack, 1);
    check("eq_busy_n1", busy, 0);
    check("eq_step_n1", phasestep, 0);
    @(negedge clk);
    check("eq_ack_n2", ack, 0);
    check("eq_busy_n2", busy, 0);

    // first-step timing
    do_req(2);
    check("t_busy_n1", busy, 1);
    check("t_step_n1", phasestep, 1);
    check("t_upd_n1", phaseupdown, 1);
    @(negedge clk);
    check("t_step_n2", phasestep, 1);
    @(negedge clk);
    check("t_step_n3", phasestep, 0);
    check("t_busy_n3", busy, 1);
    wait_idle();
    @(negedge clk);
    check("t_cur", cur, 2);

    // timeout: phasedone never falls
    stuck = 1'b1;
    b_ack = ack_cnt;
    do_req(3);
    repeat (17) @(negedge clk);
    check("to_busy_before", busy, 1);
    check("to_err_before", err, 0);
    @(negedge clk);
    check("to_err", err, 1);
    check("to_busy", busy, 0);
    check("to_cur", cur, 2);
    repeat (3) @(negedge clk);
    check("to_err_sticky", err, 1);
    check("to_no_ack", ack_cnt - b_ack, 0);
    stuck = 1'b0;
    do_req(2);
    check("to_err_cleared", err, 0);
    check("to_clear_ack", ack, 1);
    @(negedge clk);

    // lock lost during the second step
    b_ack = ack_cnt;
    do_req(4);
    rises = phasestep ? 1 : 0;
    pprev = phasestep;
    for (int i = 0; i < 200 && rises < 2; i++) begin
      @(negedge clk);
      if (phasestep && !pprev) rises++;
      pprev = phasestep;
    end
    check("drop_second_step", rises, 2);
    @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    check("drop_busy", busy, 0);
    check("drop_step", phasestep, 0);
    check("drop_cur", cur, 0);
    check("drop_err", err, 0);
    do_req(5);
    check("unlocked_req_busy", busy, 0);
    check("unlocked_req_ack", ack, 0);
    @(negedge clk);
    check("drop_no_ack", ack_cnt - b_ack, 0);
    locked = 1'b1;
    repeat (10) @(negedge clk);
    check("relock_cur", cur, 0);
    check("relock_busy", busy, 0);

    // random targets against the arithmetic model
    model_cur = 0;
    for (int k = 0; k < 40; k++) begin
      t = int'($urandom_range(0, 63)) - 32;
      pulses = (t > model_cur) ? t - model_cur : model_cur - t;
      pll_dly = int'($urandom_range(2, 5));
      pll_len = int'($urandom_range(2, 5));
      run_req($sformatf("rnd%0d", k), t, (pulses >= 2) && ($urandom_range(0, 1) == 1),
              pulses, t > model_cur, t);
      model_cur = t;
    end

    check("end_cntsel", pcs, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jtframe_pll_phstep.md
# jtframe_pll_phstep

Dynamic phase-shift controller for the SDRAM clock outputs of the framework PLL. It drives the PLL's phase-step port group (counter select, step, up/down) and tracks the PLL's `phasedone` handshake, so the SDRAM clock phase can be moved at run time instead of being fixed by the `SDRAM_SHIFT` compile-time value. It sits in the PLL's scan/reconfiguration clock domain, between the OSD/debug register bank that requests a phase offset and the PLL instance.

## Interface
- `STEPW`, 6: width of signed phase offset (two's complement, in VCO phase steps)
- `CNTW`, 4: width of `phasecounterselect`
- `CNTSEL`, 4'd1: counter-select code of the shifted SDRAM output
- `TO`, 255: max cycles spent waiting for each `phasedone` edge before timeout
- `clk`  in  1  PLL scan/reconfig clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `locked`  in  1  PLL lock, already synchronised to `clk`
- `req`  in  1  request pulse; sampled only in IDLE
- `target`  in  STEPW  signed desired offset from power-up phase
- `busy`  out  1  high while stepping
- `ack`  out  1  one-cycle pulse: target reached
- `cur`  out  STEPW  signed offset currently applied
- `err`  out  1  timeout flag
- `phasecounterselect`  out  CNTW  to PLL
- `phasestep`  out  1  to PLL
- `phaseupdown`  out  1  to PLL, 1 = advance (+1 step)
- `phasedone`  in  1  from PLL; low while a step is in progress

## Operation
- States: IDLE, STEP, WAIT_LOW, WAIT_HIGH, CHECK.
- IDLE: `req`=1 and `locked`=1 latches `target`, clears `err`. If `target`==`cur` → `ack` next cycle, stay IDLE, no PLL activity. Else → STEP; `phaseupdown` = (`target` > `cur`, signed compare), held constant until return to IDLE.
- `req` with `locked`=0, or `req` while not IDLE: ignored, no `ack`.
- STEP: `phasestep`=1 for exactly 2 cycles, then WAIT_LOW.
- WAIT_LOW: wait for `phasedone`=0, then WAIT_HIGH. WAIT_HIGH: wait for `phasedone`=1, then CHECK.
- CHECK (1 cycle): `cur` ± 1 per `phaseupdown`. If new `cur`==latched target → `ack`, IDLE. Else → STEP.
- Timeout: wait counter cleared on entry to each WAIT state; reaching `TO` cycles → `err`=1 (sticky until `rst` or next accepted `req`), IDLE, no `ack`, `cur` unchanged for the failed step.
- `locked`=0 in any non-IDLE state: abort to IDLE next cycle, `phasestep`=0, no `ack`, `err` unchanged. Any `locked`=0 cycle forces `cur`=0 (PLL relock restores compile-time phase).
- `phasecounterselect` = `CNTSEL` constantly.
- Arithmetic: `cur` in STEPW bits; targets confined to representable range, so no wrap or saturation needed.

## Timing
- Reset values: `busy`=0, `ack`=0, `cur`=0, `err`=0, `phasestep`=0, `phaseupdown`=0, `phasecounterselect`=`CNTSEL`; state IDLE.
- `req` sampled at edge n (non-equal target): `busy`=1 and `phasestep`=1 at n+1, n+2; `phaseupdown` valid from n+1, before first `phasestep` rise.
- Per step: 2 + (cycles to `phasedone` fall) + (cycles to rise) + 1.
- `ack` and `busy` fall in the same cycle; next `req` accepted the cycle after `ack`.
- Equal-target `req` at n: `ack`=1 at n+1, `busy` stays 0.
- `phasedone` already low on WAIT_LOW entry: counts as fall in one cycle.

## Test plan
- Reset, `locked`=1 → all outputs at reset values, `phasecounterselect`=1.
- PLL model (`phasedone` low 3 cycles after `phasestep` rise, for 4 cycles); `target`=3 from 0 → 3 double-cycle `phasestep` pulses, `phaseupdown`=1, `cur` 1,2,3, single `ack`, `busy`=0.
- Then `target`=-2 → 5 pulses, `phaseupdown`=0, `cur`=-2, one `ack`; `req` during stepping ignored.
- `target`=`cur`=-2 → `ack` at n+1, no `phasestep`, `busy` never high.
- Model never lowers `phasedone`, `TO`=16 → `err`=1 after 16 WAIT_LOW cycles, `busy`=0, no `ack`, `cur` unchanged; next accepted `req` clears `err`.
- `locked` dropped during second step of `target`=4 → IDLE next cycle, `phasestep`=0, `cur`=0, no `ack`; `req` while `locked`=0 ignored.
